// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - load/store sequencer between the control unit and the byte-addressed RAM
module mem_access_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [5:0]  Op,
    input  logic [31:0] Addr,
    input  logic [31:0] WrData,
    input  logic [31:0] WrData2,
    output logic        Busy,
    output logic        Done,
    output logic        Error,
    output logic [31:0] RdData,
    output logic [31:0] RdData2,
    output logic        Mem_Enable,
    output logic [5:0]  Mem_OpCode,
    output logic [6:0]  Mem_Address,
    output logic [31:0] Mem_DataIn,
    input  logic [31:0] Mem_DataOut,
    input  logic        Mem_MFC
);

    localparam logic [5:0] OP_LD   = 6'b000000;
    localparam logic [5:0] OP_LDUB = 6'b000001;
    localparam logic [5:0] OP_LDUH = 6'b000010;
    localparam logic [5:0] OP_LDD  = 6'b000011;
    localparam logic [5:0] OP_ST   = 6'b000100;
    localparam logic [5:0] OP_STB  = 6'b000101;
    localparam logic [5:0] OP_STH  = 6'b000110;
    localparam logic [5:0] OP_STD  = 6'b000111;
    localparam logic [5:0] OP_LDSB = 6'b001001;
    localparam logic [5:0] OP_LDSH = 6'b001010;
    localparam logic [5:0] OP_SWAP = 6'b001111;

    // The counter only has to reach TIMEOUT-1: the abort fires on the edge that would make it TIMEOUT.
    localparam int             CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACC1,
        S_GAP,
        S_ACC2,
        S_DONE
    } state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [5:0]        op_q, op_nxt;
    logic [6:0]        addr_q, addr_nxt;
    logic [31:0]       wdata_q, wdata_nxt;
    logic [31:0]       wdata2_q, wdata2_nxt;
    logic              busy_nxt, done_nxt, error_nxt;
    logic [31:0]       rd_nxt, rd2_nxt;
    logic              en_nxt;
    logic [5:0]        opc_nxt;
    logic [6:0]        maddr_nxt;
    logic [31:0]       din_nxt;
    logic              req_bad;
    logic              mfc_seen;

    function automatic logic op_legal(input logic [5:0] op);
        case (op)
            OP_LD, OP_LDUB, OP_LDUH, OP_LDD, OP_ST, OP_STB,
            OP_STH, OP_STD, OP_LDSB, OP_LDSH, OP_SWAP: op_legal = 1'b1;
            default:                                   op_legal = 1'b0;
        endcase
    endfunction

    function automatic logic op_aligned(input logic [5:0] op, input logic [2:0] a);
        case (op)
            OP_LD, OP_ST, OP_SWAP:   op_aligned = (a[1:0] == 2'b00);
            OP_LDUH, OP_LDSH, OP_STH: op_aligned = ~a[0];
            OP_LDD, OP_STD:          op_aligned = (a == 3'b000);
            default:                 op_aligned = 1'b1;
        endcase
    endfunction

    function automatic logic two_phase(input logic [5:0] op);
        two_phase = (op == OP_LDD) || (op == OP_STD) || (op == OP_SWAP);
    endfunction

    // Phase-1 accesses whose returned word belongs in RdData (SWAP returns the old word).
    function automatic logic loads_p1(input logic [5:0] op);
        case (op)
            OP_LD, OP_LDUB, OP_LDUH, OP_LDSB, OP_LDSH, OP_LDD, OP_SWAP: loads_p1 = 1'b1;
            default:                                                   loads_p1 = 1'b0;
        endcase
    endfunction

    // Multi-access ops are broken into plain word accesses; everything else passes through.
    function automatic logic [5:0] p1_opcode(input logic [5:0] op);
        case (op)
            OP_LDD, OP_SWAP: p1_opcode = OP_LD;
            OP_STD:          p1_opcode = OP_ST;
            default:         p1_opcode = op;
        endcase
    endfunction

    // Request screening is done on the raw inputs in the cycle Start is accepted.
    always_comb begin
        req_bad = !op_legal(Op) || (Addr[31:7] != 25'd0) || !op_aligned(Op, Addr[2:0]);
    end

    // Next-state and next-register values; every output is registered from these.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        op_nxt     = op_q;
        addr_nxt   = addr_q;
        wdata_nxt  = wdata_q;
        wdata2_nxt = wdata2_q;
        busy_nxt   = Busy;
        done_nxt   = 1'b0;
        error_nxt  = Error;
        rd_nxt     = RdData;
        rd2_nxt    = RdData2;
        en_nxt     = Mem_Enable;
        opc_nxt    = Mem_OpCode;
        maddr_nxt  = Mem_Address;
        din_nxt    = Mem_DataIn;
        // MFC in the first cycle of a phase may be left over from the previous access.
        mfc_seen   = Mem_MFC && (cnt != '0);

        case (state)
            S_IDLE: begin
                if (Start) begin
                    op_nxt     = Op;
                    addr_nxt   = Addr[6:0];
                    wdata_nxt  = WrData;
                    wdata2_nxt = WrData2;
                    busy_nxt   = 1'b1;
                    if (req_bad) begin
                        error_nxt = 1'b1;
                        done_nxt  = 1'b1;
                        state_nxt = S_DONE;
                    end else begin
                        error_nxt = 1'b0;
                        en_nxt    = 1'b1;
                        opc_nxt   = p1_opcode(Op);
                        maddr_nxt = Addr[6:0];
                        din_nxt   = WrData;
                        cnt_nxt   = '0;
                        state_nxt = S_ACC1;
                    end
                end
            end

            S_ACC1, S_ACC2: begin
                if (mfc_seen) begin
                    en_nxt = 1'b0;
                    if (state == S_ACC1) begin
                        if (loads_p1(op_q)) begin
                            rd_nxt = Mem_DataOut;
                        end
                    end else if (op_q == OP_LDD) begin
                        rd2_nxt = Mem_DataOut;
                    end
                    if ((state == S_ACC1) && two_phase(op_q)) begin
                        state_nxt = S_GAP;
                    end else begin
                        done_nxt  = 1'b1;
                        state_nxt = S_DONE;
                    end
                end else if (cnt == CNT_LAST) begin
                    en_nxt    = 1'b0;
                    error_nxt = 1'b1;
                    done_nxt  = 1'b1;
                    state_nxt = S_DONE;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end

            // One low-Enable cycle so the RAM sees a fresh Enable edge for the second access.
            S_GAP: begin
                en_nxt    = 1'b1;
                opc_nxt   = (op_q == OP_LDD) ? OP_LD : OP_ST;
                maddr_nxt = (op_q == OP_SWAP) ? addr_q : addr_q + 7'd4;
                din_nxt   = (op_q == OP_STD) ? wdata2_q : wdata_q;
                cnt_nxt   = '0;
                state_nxt = S_ACC2;
            end

            S_DONE: begin
                busy_nxt  = 1'b0;
                state_nxt = S_IDLE;
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            op_q        <= 6'd0;
            addr_q      <= 7'd0;
            wdata_q     <= 32'd0;
            wdata2_q    <= 32'd0;
            Busy        <= 1'b0;
            Done        <= 1'b0;
            Error       <= 1'b0;
            RdData      <= 32'd0;
            RdData2     <= 32'd0;
            Mem_Enable  <= 1'b0;
            Mem_OpCode  <= 6'd0;
            Mem_Address <= 7'd0;
            Mem_DataIn  <= 32'd0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            op_q        <= op_nxt;
            addr_q      <= addr_nxt;
            wdata_q     <= wdata_nxt;
            wdata2_q    <= wdata2_nxt;
            Busy        <= busy_nxt;
            Done        <= done_nxt;
            Error       <= error_nxt;
            RdData      <= rd_nxt;
            RdData2     <= rd2_nxt;
            Mem_Enable  <= en_nxt;
            Mem_OpCode  <= opc_nxt;
            Mem_Address <= maddr_nxt;
            Mem_DataIn  <= din_nxt;
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - randomized self-checking bench for mem_access_ctrl
module tb_mem_access_ctrl;

    localparam int TIMEOUT = 16;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Start = 1'b0;
    logic [5:0]  Op = 6'd0;
    logic [31:0] Addr = 32'd0;
    logic [31:0] WrData = 32'd0;
    logic [31:0] WrData2 = 32'd0;
    logic        Busy, Done, Error;
    logic [31:0] RdData, RdData2;
    logic        Mem_Enable;
    logic [5:0]  Mem_OpCode;
    logic [6:0]  Mem_Address;
    logic [31:0] Mem_DataIn;
    logic [31:0] Mem_DataOut = 32'd0;
    logic        Mem_MFC = 1'b0;

    always #5 Clk = ~Clk;

    mem_access_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .Addr(Addr),
        .WrData(WrData), .WrData2(WrData2), .Busy(Busy), .Done(Done), .Error(Error),
        .RdData(RdData), .RdData2(RdData2), .Mem_Enable(Mem_Enable),
        .Mem_OpCode(Mem_OpCode), .Mem_Address(Mem_Address), .Mem_DataIn(Mem_DataIn),
        .Mem_DataOut(Mem_DataOut), .Mem_MFC(Mem_MFC)
    );

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // RAM stub: big-endian bytes, MFC raised on the (L+1)th cycle of each Enable pulse.
    logic [7:0]  mem  [0:127];
    logic [7:0]  gold [0:127];
    int          lat_q[$];
    bit          stall = 1'b0;
    bit          stale_en = 1'b0;
    bit          armed = 1'b0;
    bit          acc_done = 1'b0;
    int          wait_left = 0;
    int          en_hi = 0;
    logic [5:0]  tr_op[$];
    logic [6:0]  tr_addr[$];
    logic [31:0] tr_din[$];

    task automatic ram_exec();
        logic [6:0] a;
        a = Mem_Address;
        case (Mem_OpCode)
            6'd0:  Mem_DataOut = {mem[a], mem[a + 7'd1], mem[a + 7'd2], mem[a + 7'd3]};
            6'd1:  Mem_DataOut = {24'd0, mem[a]};
            6'd9:  Mem_DataOut = {{24{mem[a][7]}}, mem[a]};
            6'd2:  Mem_DataOut = {16'd0, mem[a], mem[a + 7'd1]};
            6'd10: Mem_DataOut = {{16{mem[a][7]}}, mem[a], mem[a + 7'd1]};
            6'd4: begin
                mem[a]        = Mem_DataIn[31:24];
                mem[a + 7'd1] = Mem_DataIn[23:16];
                mem[a + 7'd2] = Mem_DataIn[15:8];
                mem[a + 7'd3] = Mem_DataIn[7:0];
            end
            6'd5: mem[a] = Mem_DataIn[7:0];
            6'd6: begin
                mem[a]        = Mem_DataIn[15:8];
                mem[a + 7'd1] = Mem_DataIn[7:0];
            end
            default: ;
        endcase
    endtask

    always @(negedge Clk) begin
        if (!Mem_Enable) begin
            Mem_MFC  = 1'b0;
            armed    = 1'b0;
            acc_done = 1'b0;
        end else begin
            en_hi++;
            if (!armed) begin
                armed    = 1'b1;
                acc_done = 1'b0;
                tr_op.push_back(Mem_OpCode);
                tr_addr.push_back(Mem_Address);
                tr_din.push_back(Mem_DataIn);
                wait_left = (lat_q.size() > 0) ? lat_q.pop_front() : 1;
                Mem_MFC = stale_en;
                if (stale_en) Mem_DataOut = 32'hBAD0_BAD0;
            end else if (stall) begin
                Mem_MFC = 1'b0;
            end else if (!acc_done) begin
                if (wait_left > 1) begin
                    wait_left--;
                    Mem_MFC = 1'b0;
                end else begin
                    ram_exec();
                    Mem_MFC  = 1'b1;
                    acc_done = 1'b1;
                end
            end
        end
    end

    // Alignment mask per op, -1 for an op the sequencer must refuse.
    function automatic int op_mask(input logic [5:0] op);
        case (op)
            6'd0, 6'd4, 6'd15: op_mask = 3;
            6'd2, 6'd10, 6'd6: op_mask = 1;
            6'd3, 6'd7:        op_mask = 7;
            6'd1, 6'd5, 6'd9:  op_mask = 0;
            default:           op_mask = -1;
        endcase
    endfunction

    function automatic logic [31:0] gw(input logic [6:0] a);
        return {gold[a], gold[a + 7'd1], gold[a + 7'd2], gold[a + 7'd3]};
    endfunction

    task automatic gwrite(input logic [6:0] a, input logic [31:0] w);
        gold[a] = w[31:24]; gold[a + 7'd1] = w[23:16];
        gold[a + 7'd2] = w[15:8]; gold[a + 7'd3] = w[7:0];
    endtask

    task automatic put_word(input logic [6:0] a, input logic [31:0] w);
        gwrite(a, w);
        mem[a] = w[31:24]; mem[a + 7'd1] = w[23:16];
        mem[a + 7'd2] = w[15:8]; mem[a + 7'd3] = w[7:0];
    endtask

    task automatic run_txn(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [31:0] wd2, input int l1, input int l2, input bit stray);
        int          mask, exp_n, exp_en, n, mm;
        bit          err, two, is_ld, busy_ok;
        logic [6:0]  a;
        logic [31:0] exp_rd, exp_rd2;
        logic [5:0]  e_op[$];
        logic [6:0]  e_ad[$];
        logic [31:0] e_din[$];
        mask    = op_mask(op);
        err     = (mask < 0) || (addr > 32'd127) || ((addr & 32'(mask < 0 ? 0 : mask)) != 32'd0);
        two     = (op == 6'd3) || (op == 6'd7) || (op == 6'd15);
        is_ld   = (op == 6'd0) || (op == 6'd1) || (op == 6'd2) || (op == 6'd3) ||
                  (op == 6'd9) || (op == 6'd10) || (op == 6'd15);
        a       = addr[6:0];
        exp_rd  = 32'd0;
        exp_rd2 = 32'd0;
        if (!err) begin
            case (op)
                6'd0:  begin exp_rd = gw(a); e_op.push_back(6'd0); e_ad.push_back(a); e_din.push_back(wd); end
                6'd1:  begin exp_rd = {24'd0, gold[a]}; e_op.push_back(6'd1); e_ad.push_back(a); e_din.push_back(wd); end
                6'd9:  begin exp_rd = {{24{gold[a][7]}}, gold[a]}; e_op.push_back(6'd9); e_ad.push_back(a); e_din.push_back(wd); end
                6'd2:  begin exp_rd = {16'd0, gold[a], gold[a + 7'd1]}; e_op.push_back(6'd2); e_ad.push_back(a); e_din.push_back(wd); end
                6'd10: begin exp_rd = {{16{gold[a][7]}}, gold[a], gold[a + 7'd1]}; e_op.push_back(6'd10); e_ad.push_back(a); e_din.push_back(wd); end
                6'd3: begin
                    exp_rd = gw(a); exp_rd2 = gw(a + 7'd4);
                    e_op.push_back(6'd0); e_ad.push_back(a); e_din.push_back(wd);
                    e_op.push_back(6'd0); e_ad.push_back(a + 7'd4); e_din.push_back(wd);
                end
                6'd4: begin e_op.push_back(6'd4); e_ad.push_back(a); e_din.push_back(wd); gwrite(a, wd); end
                6'd5: begin e_op.push_back(6'd5); e_ad.push_back(a); e_din.push_back(wd); gold[a] = wd[7:0]; end
                6'd6: begin
                    e_op.push_back(6'd6); e_ad.push_back(a); e_din.push_back(wd);
                    gold[a] = wd[15:8]; gold[a + 7'd1] = wd[7:0];
                end
                6'd7: begin
                    e_op.push_back(6'd4); e_ad.push_back(a); e_din.push_back(wd);
                    e_op.push_back(6'd4); e_ad.push_back(a + 7'd4); e_din.push_back(wd2);
                    gwrite(a, wd); gwrite(a + 7'd4, wd2);
                end
                default: begin
                    exp_rd = gw(a);
                    e_op.push_back(6'd0); e_ad.push_back(a); e_din.push_back(wd);
                    e_op.push_back(6'd4); e_ad.push_back(a); e_din.push_back(wd);
                    gwrite(a, wd);
                end
            endcase
        end
        exp_n  = err ? 1 : (two ? l1 + l2 + 4 : l1 + 2);
        exp_en = err ? 0 : (two ? l1 + l2 + 2 : l1 + 1);

        lat_q.delete(); lat_q.push_back(l1); lat_q.push_back(l2);
        tr_op.delete(); tr_addr.delete(); tr_din.delete();
        en_hi = 0;
        @(negedge Clk);
        Start = 1'b1; Op = op; Addr = addr; WrData = wd; WrData2 = wd2;
        @(posedge Clk);
        n = 1;
        busy_ok = 1'b1;
        @(negedge Clk);
        Start = 1'b0; Op = 6'($urandom); Addr = $urandom; WrData = $urandom; WrData2 = $urandom;
        while (!Done && n < 100) begin
            if (!Busy) busy_ok = 1'b0;
            @(posedge Clk);
            n++;
            @(negedge Clk);
        end
        check_eq("done_seen", 32'(Done), 32'd1);
        check_eq("latency", 32'(n), 32'(exp_n));
        check_eq("busy_held", 32'(busy_ok & Busy), 32'd1);
        check_eq("error", 32'(Error), 32'(err));
        check_eq("enable_cycles", 32'(en_hi), 32'(exp_en));
        if (!err && is_ld) check_eq("rd_data", RdData, exp_rd);
        if (!err && op == 6'd3) check_eq("rd_data2", RdData2, exp_rd2);
        check_eq("access_count", 32'(tr_op.size()), 32'(e_op.size()));
        for (int i = 0; i < e_op.size() && i < tr_op.size(); i++) begin
            check_eq("access_opcode", 32'(tr_op[i]), 32'(e_op[i]));
            check_eq("access_addr", 32'(tr_addr[i]), 32'(e_ad[i]));
            if (e_op[i] == 6'd4 || e_op[i] == 6'd5 || e_op[i] == 6'd6)
                check_eq("access_din", tr_din[i], e_din[i]);
        end

        if (stray) begin
            Start = 1'b1; Op = 6'd0; Addr = 32'($urandom_range(0, 31)) << 2;
        end
        @(posedge Clk);
        @(negedge Clk);
        Start = 1'b0;
        check_eq("done_pulse", 32'(Done), 32'd0);
        check_eq("busy_idle", 32'(Busy), 32'd0);
        check_eq("error_hold", 32'(Error), 32'(err));
        @(posedge Clk);
        @(negedge Clk);
        check_eq("no_restart", 32'({Mem_Enable, Busy}), 32'd0);

        mm = 0;
        for (int i = 0; i < 128; i++) if (mem[i] !== gold[i]) mm++;
        check_eq("mem_image", 32'(mm), 32'd0);
    endtask

    initial begin
        logic [5:0]  legal_ops [11];
        logic [5:0]  op;
        logic [31:0] addr;
        int          mask, sel, base, n, k;
        bit          seen;

        legal_ops = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd9, 6'd10, 6'd15};
        for (int i = 0; i < 128; i++) begin
            mem[i]  = 8'($urandom);
            gold[i] = mem[i];
        end

        repeat (2) @(posedge Clk);
        @(negedge Clk);
        check_eq("rst_flags", 32'({Busy, Done, Error, Mem_Enable}), 32'd0);
        check_eq("rst_rd", RdData, 32'd0);
        check_eq("rst_rd2", RdData2, 32'd0);
        check_eq("rst_mem_ctl", 32'({Mem_OpCode, Mem_Address}), 32'd0);
        check_eq("rst_mem_din", Mem_DataIn, 32'd0);
        Reset = 1'b0;

        // Directed cases.
        put_word(7'h10, 32'hDEADBEEF);
        run_txn(6'd0, 32'h10, 32'd0, 32'd0, 3, 1, 1'b0);
        run_txn(6'd0, 32'h10, 32'd0, 32'd0, 1, 1, 1'b1);
        run_txn(6'd7, 32'h08, 32'h11223344, 32'h55667788, 1, 1, 1'b0);
        run_txn(6'd3, 32'h08, 32'd0, 32'd0, 2, 3, 1'b0);
        put_word(7'h20, 32'hCAFEF00D);
        stale_en = 1'b1;
        run_txn(6'd15, 32'h20, 32'h12345678, 32'd0, 2, 2, 1'b0);
        run_txn(6'd0, 32'h20, 32'd0, 32'd0, 2, 1, 1'b0);
        stale_en = 1'b0;
        run_txn(6'd0, 32'h12, 32'd0, 32'd0, 1, 1, 1'b0);
        run_txn(6'd3, 32'h04, 32'd0, 32'd0, 1, 1, 1'b1);
        run_txn(6'd12, 32'h00, 32'd0, 32'd0, 1, 1, 1'b0);
        run_txn(6'd0, 32'h80, 32'd0, 32'd0, 1, 1, 1'b0);

        // Timeout: MFC never arrives.
        stall = 1'b1;
        lat_q.delete(); tr_op.delete(); tr_addr.delete(); tr_din.delete();
        en_hi = 0;
        @(negedge Clk);
        Start = 1'b1; Op = 6'd0; Addr = 32'h0;
        @(posedge Clk);
        n = 1;
        @(negedge Clk);
        Start = 1'b0;
        while (!Done && n < 100) begin
            @(posedge Clk);
            n++;
            @(negedge Clk);
        end
        check_eq("to_done", 32'(Done), 32'd1);
        check_eq("to_latency", 32'(n), 32'(TIMEOUT + 1));
        check_eq("to_enable_cycles", 32'(en_hi), 32'(TIMEOUT));
        check_eq("to_error", 32'(Error), 32'd1);
        @(posedge Clk);
        @(negedge Clk);
        check_eq("to_done_pulse", 32'({Done, Mem_Enable}), 32'd0);
        stall = 1'b0;

        // Reset during the second phase of an LDD.
        lat_q.delete(); lat_q.push_back(1); lat_q.push_back(6);
        tr_op.delete(); tr_addr.delete(); tr_din.delete();
        @(negedge Clk);
        Start = 1'b1; Op = 6'd3; Addr = 32'h40;
        @(posedge Clk);
        @(negedge Clk);
        Start = 1'b0;
        k = 0;
        while (tr_op.size() < 2 && k < 50) begin
            @(posedge Clk);
            @(negedge Clk);
            k++;
        end
        check_eq("rst_reached_acc2", 32'(tr_op.size()), 32'd2);
        Reset = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        check_eq("midrst_flags", 32'({Busy, Done, Error, Mem_Enable}), 32'd0);
        check_eq("midrst_rd", RdData, 32'd0);
        check_eq("midrst_rd2", RdData2, 32'd0);
        check_eq("midrst_mem_ctl", 32'({Mem_OpCode, Mem_Address}), 32'd0);
        check_eq("midrst_mem_din", Mem_DataIn, 32'd0);
        seen = 1'b0;
        repeat (8) begin
            @(posedge Clk);
            @(negedge Clk);
            if (Done || Mem_Enable) seen = 1'b1;
        end
        check_eq("midrst_quiet", 32'(seen), 32'd0);
        lat_q.delete();
        run_txn(6'd0, 32'h40, 32'd0, 32'd0, 2, 1, 1'b0);

        // Randomized requests.
        for (int t = 0; t < 60; t++) begin
            if ($urandom_range(0, 11) == 11) begin
                do op = 6'($urandom); while (op_mask(op) >= 0);
            end else begin
                op = legal_ops[$urandom_range(0, 10)];
            end
            mask = op_mask(op);
            if (mask < 0) mask = 0;
            sel  = $urandom_range(0, 9);
            base = $urandom_range(0, 127);
            if (sel < 8)       addr = 32'(base & ~mask);
            else if (sel == 8) addr = 32'(base);
            else               addr = 32'(base) | (32'd1 << $urandom_range(7, 31));
            stale_en = 1'($urandom_range(0, 1));
            run_txn(op, addr, $urandom, $urandom, $urandom_range(1, 4), $urandom_range(1, 4),
                    1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
